// File: rtl/pc_pkg.sv
// Shared types and defaults for the cpu1 program-counter slice.
package pc_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT = 4;

    typedef enum logic {
        PC_RUN,
        PC_HALT
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_LOAD
    } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the sequencer (master) and pc_unit (slave).
interface pc_unit_if #(
    parameter int unsigned WIDTH = pc_pkg::PC_WIDTH_DEFAULT
);

    logic             inc_en;
    logic             load;
    logic             load_nc;
    logic [WIDTH-1:0] load_val;
    logic             carry_we;
    logic             carry_in;
    logic [WIDTH-1:0] pc;
    logic             carry_flag;
    logic             pc_wrap;
    logic             halted;

    modport master (
        output inc_en, load, load_nc, load_val, carry_we, carry_in,
        input  pc, carry_flag, pc_wrap, halted
    );

    modport slave (
        input  inc_en, load, load_nc, load_val, carry_we, carry_in,
        output pc, carry_flag, pc_wrap, halted
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: load > taken JNC > increment > hold.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             carry_flag,
    input  logic             inc_en,
    input  logic             load,
    input  logic             load_nc,
    input  logic [WIDTH-1:0] load_val,
    output pc_sel_e          sel,
    output logic [WIDTH-1:0] pc_next,
    output logic             wrap,
    output logic             jump_taken
);

    // Priority decode of the PC source and the resulting next value
    always_comb begin
        sel        = SEL_HOLD;
        pc_next    = pc;
        wrap       = 1'b0;
        // JNC looks at the flag as it stood before this edge
        jump_taken = load | (load_nc & ~carry_flag);

        if (jump_taken) begin
            sel = SEL_LOAD;
        end else if (inc_en) begin
            sel = SEL_INC;
        end

        case (sel)
            SEL_LOAD: pc_next = load_val;
            SEL_INC: begin
                pc_next = pc + WIDTH'(1);
                wrap    = (pc == '1);
            end
            default:  pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter and carry flag for the cpu1 core.
// Optional feature macro: PC_HALT_EN (RUN/HALT jump-to-self detector).
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH     = PC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             carry_q, carry_d;
    logic             wrap_q, wrap_d;
    logic             run;

    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_next;
    logic             wrap;
    logic             jump_taken;

    pc_next_sel #(
        .WIDTH (WIDTH)
    ) u_next_sel (
        .pc         (pc_q),
        .carry_flag (carry_q),
        .inc_en     (bus.inc_en),
        .load       (bus.load),
        .load_nc    (bus.load_nc),
        .load_val   (bus.load_val),
        .sel        (sel),
        .pc_next    (pc_next),
        .wrap       (wrap),
        .jump_taken (jump_taken)
    );

`ifdef PC_HALT_EN
    pc_state_e state_q, state_d;

    assign run = (state_q == PC_RUN);

    // RUN -> HALT on a taken jump whose target is the current pc; only reset leaves HALT
    always_comb begin
        state_d = state_q;
        if (run && jump_taken && (bus.load_val == pc_q)) begin
            state_d = PC_HALT;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PC_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.halted = (state_q == PC_HALT);
`else
    logic unused_jump_taken;

    assign run               = 1'b1;
    assign unused_jump_taken = jump_taken;
    assign bus.halted        = 1'b0;
`endif

    // Next values for pc, carry and wrap pulse; everything freezes while not running
    always_comb begin
        pc_d    = pc_q;
        carry_d = carry_q;
        wrap_d  = 1'b0;
        if (run) begin
            pc_d   = pc_next;
            wrap_d = wrap && (sel == SEL_INC);
            if (bus.carry_we) begin
                carry_d = bus.carry_in;
            end
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            carry_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            carry_q <= carry_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.carry_flag = carry_q;
    assign bus.pc_wrap    = wrap_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit with a behavioural reference model.
module tb_pc_unit;

    localparam int unsigned W = 4;
    localparam int unsigned RV = 0;
`ifdef PC_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int   m_pc;
    bit   m_c, m_wrap, m_halt;

    pc_unit_if #(.WIDTH(W)) bus ();

    pc_unit #(
        .WIDTH     (W),
        .RESET_VEC (4'(RV))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic set_in(input bit r, input bit inc, input bit ld, input bit lnc,
                          input int lv, input bit cwe, input bit cin);
        rst          = r;
        bus.inc_en   = inc;
        bus.load     = ld;
        bus.load_nc  = lnc;
        bus.load_val = 4'(lv);
        bus.carry_we = cwe;
        bus.carry_in = cin;
    endtask

    // Reference behaviour applied at each rising edge
    task automatic model_edge();
        bit taken;
        if (rst) begin
            m_pc = RV; m_c = 0; m_wrap = 0; m_halt = 0;
        end else if (m_halt) begin
            m_wrap = 0;
        end else begin
            taken  = bus.load || (bus.load_nc && !m_c);
            m_wrap = 0;
            if (taken) begin
                if (HALT_EN && (int'(bus.load_val) == m_pc)) m_halt = 1;
                m_pc = int'(bus.load_val);
            end else if (bus.inc_en) begin
                m_wrap = (m_pc == (1 << W) - 1);
                m_pc   = (m_pc + 1) % (1 << W);
            end
            if (bus.carry_we) m_c = bus.carry_in;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 1, 0, 9, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", bus.pc); end
        checks++;
        if (bus.carry_flag !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", bus.carry_flag); end
        checks++;
        if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
        checks++;
        if (bus.pc_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", bus.pc_wrap); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_pc [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        logic       exp_w  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        set_in(0, 0, 1, 0, 14, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (bus.pc !== exp_pc[i] || bus.pc_wrap !== exp_w[i]) begin
                errors++;
                $display("FAIL wrap step %0d got pc=%0d wrap=%b want pc=%0d wrap=%b",
                         i, bus.pc, bus.pc_wrap, exp_pc[i], exp_w[i]);
            end
            set_in(0, 1, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_priority();
        set_in(0, 0, 1, 0, 3, 0, 0);
        cycle();
        set_in(0, 1, 1, 1, 10, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 4'd10) begin errors++; $display("FAIL priority_load got %0d want 10", bus.pc); end
        set_in(0, 1, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 4'd11) begin errors++; $display("FAIL priority_inc got %0d want 11", bus.pc); end
    endtask

    task automatic test_jnc();
        set_in(0, 0, 1, 0, 2, 1, 1);
        cycle();
        checks++;
        if (bus.pc !== 4'd2 || bus.carry_flag !== 1'b1) begin
            errors++; $display("FAIL jnc_setup got pc=%0d c=%b want pc=2 c=1", bus.pc, bus.carry_flag);
        end
        set_in(0, 1, 0, 1, 6, 1, 0);
        cycle();
        checks++;
        if (bus.pc !== 4'd3) begin errors++; $display("FAIL jnc_not_taken got %0d want 3", bus.pc); end
        checks++;
        if (bus.carry_flag !== 1'b0) begin errors++; $display("FAIL jnc_carry_write got %b want 0", bus.carry_flag); end
        set_in(0, 0, 0, 1, 6, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 4'd6) begin errors++; $display("FAIL jnc_taken got %0d want 6", bus.pc); end
    endtask

    task automatic test_halt();
        set_in(0, 0, 1, 0, 5, 0, 0);
        cycle();
        set_in(0, 0, 1, 0, 5, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 4'd5 || bus.halted !== HALT_EN) begin
            errors++; $display("FAIL halt_enter got pc=%0d halted=%b want pc=5 halted=%b", bus.pc, bus.halted, HALT_EN);
        end
        for (int i = 0; i < 10; i++) begin
            set_in(0, 1, 0, 0, 0, 1, 1);
            cycle();
            checks++;
            if (bus.pc !== 4'(m_pc) || bus.carry_flag !== m_c || bus.halted !== m_halt || bus.pc_wrap !== m_wrap) begin
                errors++;
                $display("FAIL halt_freeze %0d got pc=%0d c=%b h=%b w=%b want pc=%0d c=%b h=%b w=%b",
                         i, bus.pc, bus.carry_flag, bus.halted, bus.pc_wrap, m_pc, m_c, m_halt, m_wrap);
            end
        end
        if (HALT_EN) begin
            checks++;
            if (bus.pc !== 4'd5 || bus.carry_flag !== 1'b0) begin
                errors++; $display("FAIL halt_frozen got pc=%0d c=%b want pc=5 c=0", bus.pc, bus.carry_flag);
            end
        end
        set_in(1, 1, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 4'd0 || bus.halted !== 1'b0) begin
            errors++; $display("FAIL halt_exit got pc=%0d halted=%b want pc=0 halted=0", bus.pc, bus.halted);
        end
    endtask

    task automatic test_reset_mid_run();
        set_in(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle();
        checks++;
        if (bus.pc !== 4'd7) begin errors++; $display("FAIL midrun_count got %0d want 7", bus.pc); end
        set_in(1, 1, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        if (bus.pc !== 4'd0) begin errors++; $display("FAIL midrun_reset got %0d want 0", bus.pc); end
        set_in(0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            checks++;
            if (bus.pc !== 4'(i)) begin errors++; $display("FAIL midrun_resume got %0d want %0d", bus.pc, i); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), 1'($urandom));
            cycle();
            checks++;
            if (bus.pc !== 4'(m_pc) || bus.carry_flag !== m_c || bus.pc_wrap !== m_wrap || bus.halted !== m_halt) begin
                errors++;
                $display("FAIL random %0d got pc=%0d c=%b w=%b h=%b want pc=%0d c=%b w=%b h=%b",
                         i, bus.pc, bus.carry_flag, bus.pc_wrap, bus.halted, m_pc, m_c, m_wrap, m_halt);
            end
        end
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        m_pc = 0; m_c = 0; m_wrap = 0; m_halt = 0;
        test_reset();
        test_wrap();
        test_priority();
        test_jnc();
        test_halt();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
